jtag_halt_ctrl: RTL and testbench



---
 rtl/jtag_halt_ctrl_if.sv | 28 ++
 rtl/jtag_halt_ctrl.sv | 171 +++++++++++++++++
 tb/tb_jtag_halt_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/jtag_halt_ctrl_if.sv
// jtag_halt_ctrl_if - debug-module <-> core halt/reset control signals.
//   halt_req_i  : DM halt request (level)
//   reset_req_i : DM core-reset request (acted on at rising edge)
//   core_idle_i : core pipeline drained, no bus transaction outstanding
//   core_halt_o : core stall
//   core_rst_o  : active-high core reset pulse
//   halted_o    : halted status back to the DM
//   timeout_o   : sticky, halt was forced after waiting too long for idle
// master: request/idle source (DM + core side); slave: jtag_halt_ctrl.
interface jtag_halt_ctrl_if;
  logic halt_req_i;
  logic reset_req_i;
  logic core_idle_i;
  logic core_halt_o;
  logic core_rst_o;
  logic halted_o;
  logic timeout_o;

  modport master (
    output halt_req_i, reset_req_i, core_idle_i,
    input  core_halt_o, core_rst_o, halted_o, timeout_o
  );

  modport slave (
    input  halt_req_i, reset_req_i, core_idle_i,
    output core_halt_o, core_rst_o, halted_o, timeout_o
  );
endinterface

// File: rtl/jtag_halt_ctrl.sv
// jtag_halt_ctrl - sequences core halt, resume and reset for the JTAG DM.
// Turns the DM's level halt request and edge-triggered reset request into a
// core stall, a RST_CYCLES-wide core reset pulse and a halted status.
//
// Parameters:
//   RST_CYCLES     : core reset pulse width in clk cycles (>= 2)
//   TIMEOUT_CYCLES : max cycles waiting for core_idle_i before a forced halt
//                    (>= 2, only used when JTAG_HALT_TIMEOUT_EN is defined)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : jtag_halt_ctrl_if.slave (requests in, stall/reset/status out)
// Build option:
//   JTAG_HALT_TIMEOUT_EN : enables the halt-wait timeout counter; when
//                          undefined, timeout_o is tied to 0.
module jtag_halt_ctrl #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  jtag_halt_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_WAIT = 2'd1,
    HALTED    = 2'd2,
    RESET     = 2'd3
  } state_t;

  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  state_t state_q, state_d;

  logic reset_req_q;
  logic rst_edge;
  logic [RCW-1:0] rst_cnt_q;
  logic rst_done;
  logic tmo_hit;

  logic core_halt_q, core_halt_d;
  logic core_rst_q, core_rst_d;
  logic halted_q, halted_d;

  assign rst_edge = bus.reset_req_i & ~reset_req_q;
  assign rst_done = (rst_cnt_q == RST_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reset_req_q <= 1'b0;
    end else begin
      reset_req_q <= bus.reset_req_i;
    end
  end

  // Counter is held at zero outside RESET, so it starts from zero on entry
  // and saturates at the terminal count while in RESET.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q <= '0;
    end else if (state_q != RESET) begin
      rst_cnt_q <= '0;
    end else if (!rst_done) begin
      rst_cnt_q <= rst_cnt_q + 1'b1;
    end
  end

`ifdef JTAG_HALT_TIMEOUT_EN
  localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

  logic [TCW-1:0] tmo_cnt_q;
  logic timeout_q, timeout_d;

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q != HALT_WAIT) begin
      tmo_cnt_q <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Sticky: set only when HALTED is reached by timeout rather than by idle,
  // cleared whenever the FSM returns to RUN.
  always_comb begin
    timeout_d = timeout_q;
    if (state_d == RUN) begin
      timeout_d = 1'b0;
    end else if ((state_q == HALT_WAIT) && (state_d == HALTED) && !bus.core_idle_i) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign tmo_hit       = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (bus.halt_req_i) state_d = HALT_WAIT;
      end
      HALT_WAIT: begin
        // Withdrawal beats idle when both arrive together.
        if (!bus.halt_req_i)      state_d = RUN;
        else if (bus.core_idle_i) state_d = HALTED;
        else if (tmo_hit)         state_d = HALTED;
      end
      HALTED: begin
        if (!bus.halt_req_i) state_d = RUN;
      end
      RESET: begin
        if (rst_done) state_d = bus.halt_req_i ? HALTED : RUN;
      end
      default: state_d = RUN;
    endcase
    // A reset request overrides everything, except while already in RESET.
    if (rst_edge && (state_q != RESET)) state_d = RESET;
  end

  // Output logic: decoded from the next state so the registered outputs
  // line up with the state register.
  always_comb begin
    core_halt_d = (state_d != RUN);
    core_rst_d  = (state_d == RESET);
    halted_d    = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_halt_q <= 1'b0;
      core_rst_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      core_halt_q <= core_halt_d;
      core_rst_q  <= core_rst_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.core_halt_o = core_halt_q;
  assign bus.core_rst_o  = core_rst_q;
  assign bus.halted_o    = halted_q;

endmodule

// File: tb/tb_jtag_halt_ctrl.sv
module tb_jtag_halt_ctrl;

  logic clk;
  logic rst_n;
  int unsigned n_assert;
  int unsigned n_fail;

  jtag_halt_ctrl_if bus ();

  jtag_halt_ctrl #(
    .RST_CYCLES     (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic h, input logic r,
                         input logic hd, input logic t);
    chk({tag, ".core_halt"}, bus.core_halt_o, h);
    chk({tag, ".core_rst"},  bus.core_rst_o,  r);
    chk({tag, ".halted"},    bus.halted_o,    hd);
    chk({tag, ".timeout"},   bus.timeout_o,   t);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.halt_req_i  = 1'b0;
    bus.reset_req_i = 1'b0;
    bus.core_idle_i = 1'b0;

    // Reset state
    tick();
    tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Halt / idle / resume
    bus.halt_req_i = 1'b1;
    tick();
    chk_all("halt_n1", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("halt_wait.halted", bus.halted_o, 1'b0);
    bus.core_idle_i = 1'b1;
    tick();
    chk_all("idle_m1", 1'b1, 1'b0, 1'b1, 1'b0);
    bus.halt_req_i = 1'b0;
    tick();
    chk_all("resume_r1", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.core_idle_i = 1'b0;
    tick();

    // Reset pulse: request held 40 cycles, one 16-cycle pulse
    bus.reset_req_i = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk($sformatf("rst_pulse[%0d]", i), bus.core_rst_o, (i <= 16) ? 1'b1 : 1'b0);
      if (i == 1)  chk("rst_pulse.halt_during", bus.core_halt_o, 1'b1);
      if (i == 17) chk_all("rst_pulse.after", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bus.reset_req_i = 1'b0;
    tick();

    // Halt-on-reset, with a second edge mid-pulse that must be ignored
    bus.halt_req_i  = 1'b1;
    bus.reset_req_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("hor_pulse[%0d]", i), bus.core_rst_o, 1'b1);
      if (i == 3) bus.reset_req_i = 1'b0;
      if (i == 5) bus.reset_req_i = 1'b1;
    end
    tick();
    chk_all("hor_after", 1'b1, 1'b0, 1'b1, 1'b0);
    bus.reset_req_i = 1'b0;
    tick();
    chk("hor_hold.halted", bus.halted_o, 1'b1);

    // HALTED: reset edge together with withdrawal -> RESET
    bus.reset_req_i = 1'b1;
    bus.halt_req_i  = 1'b0;
    tick();
    chk_all("halted_edge", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 2; i <= 16; i++) tick();
    chk("halted_edge.last", bus.core_rst_o, 1'b1);
    tick();
    chk_all("halted_edge.run", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.reset_req_i = 1'b0;
    tick();

    // HALT_WAIT: withdrawal and idle together -> RUN, never halted
    bus.halt_req_i = 1'b1;
    tick();
    chk("hw_simul.enter", bus.core_halt_o, 1'b1);
    bus.halt_req_i  = 1'b0;
    bus.core_idle_i = 1'b1;
    tick();
    chk_all("hw_simul.run", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("hw_simul.stay", bus.halted_o, 1'b0);
    bus.core_idle_i = 1'b0;
    tick();

`ifdef JTAG_HALT_TIMEOUT_EN
    // Timeout: halt at cycle 0, forced halt at cycle 9
    bus.halt_req_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("tmo_wait[%0d].halted", i), bus.halted_o, 1'b0);
      chk($sformatf("tmo_wait[%0d].timeout", i), bus.timeout_o, 1'b0);
    end
    tick();
    chk_all("tmo_hit", 1'b1, 1'b0, 1'b1, 1'b1);
    bus.halt_req_i = 1'b0;
    tick();
    chk_all("tmo_clear", 1'b0, 1'b0, 1'b0, 1'b0);
`else
    // No timeout: halt never completes without idle
    bus.halt_req_i = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      chk($sformatf("no_tmo[%0d]", i), bus.halted_o, 1'b0);
    end
    chk_all("no_tmo.end", 1'b1, 1'b0, 1'b0, 1'b0);
    bus.halt_req_i = 1'b0;
    tick();
    chk_all("no_tmo.run", 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    tick();

    // Async reset at pulse cycle 5 truncates the pulse
    bus.reset_req_i = 1'b1;
    for (int i = 1; i <= 5; i++) tick();
    chk("mid_rst.pulse5", bus.core_rst_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("mid_rst.async", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.reset_req_i = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all($sformatf("mid_rst.after[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
